dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 8, meaning data memory address width.
REQ-002 SHALL have parameter DW, default 8, meaning data memory word width.
REQ-003 SHALL have parameter LOCK_MAX, default 4, meaning the maximum number of consecutive locked host grants while the core waits.
REQ-004 SHALL have port Clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have ports core_rd / core_wr  input  1 each  core read and write requests (from RenD/WenD).
REQ-007 SHALL have ports core_addr  input  AW, core_wdata  input  DW, core_rdata  output  DW.
REQ-008 SHALL have port core_stall  output  1  high when the core requests but is not granted; holds the PC.
REQ-009 SHALL have ports host_req, host_we, host_lock  input  1 each  host request, write select and burst lock.
REQ-010 SHALL have ports host_addr  input  AW, host_wdata  input  DW.
REQ-011 SHALL have ports host_gnt  output  1, host_rdata  output  DW, host_rvalid  output  1.
REQ-012 SHALL have ports mem_wr_en, mem_rd_en  output  1, mem_addr  output  AW, mem_wdata  output  DW, mem_rdata  input  DW.
REQ-013 SHALL have port stall_cnt  output  16  saturating count of core stall cycles.

Function
REQ-014 SHALL treat the core as requesting when core_rd | core_wr; core_wr takes precedence over core_rd.
REQ-015 SHALL decide grants combinationally in the current cycle from the current requests plus registered state.
REQ-016 SHALL keep owner state IDLE, CORE, HOST or HOST_LK, which records the grant of the previous cycle.
REQ-017 SHALL grant a lone requester immediately, in any state.
REQ-018 SHALL, when both request and no lock applies, grant the requester not granted most recently, as tracked by register last_gnt.
REQ-019 SHALL enter HOST_LK when the host is granted with host_lock=1, and keep granting the host while host_req & host_lock remain high.
REQ-020 SHALL keep lock_cnt, which is 1 on the first locked host grant and increments on each further consecutive host grant.
REQ-021 SHALL grant the core in the next cycle when lock_cnt = LOCK_MAX and core_req=1, and clear lock_cnt at that point.
REQ-022 SHALL clear lock_cnt whenever the host is not granted or host_lock=0.
REQ-023 SHALL move to IDLE on any cycle with no requests; last_gnt is kept.
REQ-024 SHALL drive the granted requester's address, data and enable onto mem_*, and drive mem_wr_en = mem_rd_en = 0 when nothing is granted.
REQ-025 SHALL pass mem_rdata to core_rdata combinationally; the value is meaningful only when the core is granted a read.
REQ-026 SHALL register mem_rdata into host_rdata on a granted host read, and pulse host_rvalid high for exactly the next cycle.
REQ-027 SHALL set core_stall = core_req & ~core_gnt.
REQ-028 SHALL increment stall_cnt on each stall cycle, saturating at 16'hFFFF.
REQ-029 SHALL never assert more than one grant in any cycle.
REQ-030 SHALL ignore a host_lock that is raised without host_req.

Reset
REQ-031 SHALL, while Reset=1 (asynchronous), force owner=IDLE, last_gnt=HOST (so the core wins the first tie), lock_cnt=0, stall_cnt=0, host_rdata=0 and host_rvalid=0.
REQ-032 SHALL, while Reset=1, force host_gnt=0, mem_wr_en=0 and mem_rd_en=0, with core_stall = core_req.
REQ-033 SHALL, if Reset asserts in the middle of a locked burst, abandon the burst; the first cycle after release arbitrates with the core favoured.

Verification
REQ-034 SHALL cover: core_rd only, addr 8'h10, mem_rdata 8'hA5 -> same cycle mem_rd_en=1, mem_addr=8'h10, core_rdata=8'hA5, core_stall=0.
REQ-035 SHALL cover: core and host both request in the first cycle after reset -> core granted, host_gnt=0; next cycle, with both still requesting, host granted and core_stall=1, stall_cnt=1.
REQ-036 SHALL cover: host read of addr 8'h20 with mem_rdata 8'h3C -> host_gnt=1 that cycle, host_rdata=8'h3C and host_rvalid=1 the next cycle only.
REQ-037 SHALL cover: host_lock=1 burst while core_wr is held, LOCK_MAX=4 -> host granted 4 consecutive cycles, the core granted on cycle 5, stall_cnt=4.
REQ-038 SHALL cover: core_rd and core_wr together, addr 8'h05, data 8'h77 -> mem_wr_en=1, mem_rd_en=0, mem_wdata=8'h77.
REQ-039 SHALL cover: preload stall_cnt to 16'hFFFE, then 3 stall cycles -> stall_cnt=16'hFFFF; then Reset mid-burst -> all outputs reach their reset values without a clock edge.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bundles the core, host and data-memory buses of the data memory arbiter.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface dmem_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          core_rd;
  logic          core_wr;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata;
  logic [DW-1:0] core_rdata;
  logic          core_stall;

  logic          host_req;
  logic          host_we;
  logic          host_lock;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_gnt;
  logic [DW-1:0] host_rdata;
  logic          host_rvalid;

  logic          mem_wr_en;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic [15:0]   stall_cnt;

  modport slave (
    input  core_rd, core_wr, core_addr, core_wdata,
    output core_rdata, core_stall,
    input  host_req, host_we, host_lock, host_addr, host_wdata,
    output host_gnt, host_rdata, host_rvalid,
    output mem_wr_en, mem_rd_en, mem_addr, mem_wdata,
    input  mem_rdata,
    output stall_cnt
  );

  modport master (
    output core_rd, core_wr, core_addr, core_wdata,
    input  core_rdata, core_stall,
    output host_req, host_we, host_lock, host_addr, host_wdata,
    input  host_gnt, host_rdata, host_rvalid,
    input  mem_wr_en, mem_rd_en, mem_addr, mem_wdata,
    output mem_rdata,
    input  stall_cnt
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter between the CPU core and an external host.
// Grants are combinational; a locked host burst is capped at LOCK_MAX while the core waits.
module dmem_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int LOCK_MAX = 4
) (
  input  logic          Clk,
  input  logic          Reset,
  dmem_arbiter_if.slave bus
);
  localparam int LCW = $clog2(LOCK_MAX + 1);
  localparam logic [LCW-1:0] LOCK_LIM = LCW'(LOCK_MAX);

  typedef enum logic [1:0] {IDLE, CORE, HOST, HOST_LK} owner_t;
  typedef enum logic {GNT_CORE, GNT_HOST} gnt_t;

  owner_t         owner_q, owner_d;
  gnt_t           last_q, last_d;
  logic [LCW-1:0] lock_q, lock_d;
  logic [15:0]    stall_q;
  logic [DW-1:0]  host_rdata_q;
  logic           host_rvalid_q;

  logic          core_req, core_gnt, host_gnt, lock_hold;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_wr_en, mem_rd_en;

  // Grant decision; reset masks every grant so the memory sees no enables.
  // NOTE: every signal gets a default before the if/case so no latch is inferred.
  always_comb begin
    core_req  = bus.core_rd | bus.core_wr;
    lock_hold = (owner_q == HOST_LK) & bus.host_req & bus.host_lock;
    core_gnt  = 1'b0;
    host_gnt  = 1'b0;
    if (!Reset) begin
      if (core_req && !bus.host_req) begin
        core_gnt = 1'b1;
      end else if (bus.host_req && !core_req) begin
        host_gnt = 1'b1;
      end else if (core_req && bus.host_req) begin
        if (lock_hold) begin
          if (lock_q >= LOCK_LIM) core_gnt = 1'b1;
          else                    host_gnt = 1'b1;
        end else if (last_q == GNT_HOST) begin
          core_gnt = 1'b1;
        end else begin
          host_gnt = 1'b1;
        end
      end
    end
  end

  // Owner records this cycle's grant; the lock count only survives consecutive locked host grants.
  always_comb begin
    owner_d = IDLE;
    last_d  = last_q;
    lock_d  = '0;
    if (core_gnt) begin
      owner_d = CORE;
      last_d  = GNT_CORE;
    end else if (host_gnt) begin
      last_d = GNT_HOST;
      if (bus.host_lock) begin
        owner_d = HOST_LK;
        lock_d  = (lock_q >= LOCK_LIM) ? LOCK_LIM : lock_q + 1'b1;
      end else begin
        owner_d = HOST;
      end
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wr_en = 1'b0;
    mem_rd_en = 1'b0;
    if (core_gnt) begin
      mem_addr  = bus.core_addr;
      mem_wdata = bus.core_wdata;
      mem_wr_en = bus.core_wr;
      mem_rd_en = ~bus.core_wr;
    end else if (host_gnt) begin
      mem_addr  = bus.host_addr;
      mem_wdata = bus.host_wdata;
      mem_wr_en = bus.host_we;
      mem_rd_en = ~bus.host_we;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      owner_q       <= IDLE;
      last_q        <= GNT_HOST;
      lock_q        <= '0;
      stall_q       <= '0;
      host_rdata_q  <= '0;
      host_rvalid_q <= 1'b0;
    end else begin
      owner_q       <= owner_d;
      last_q        <= last_d;
      lock_q        <= lock_d;
      host_rvalid_q <= host_gnt & ~bus.host_we;
      if (host_gnt && !bus.host_we) host_rdata_q <= bus.mem_rdata;
      if (core_req && !core_gnt && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
    end
  end

  assign bus.core_rdata  = bus.mem_rdata;
  assign bus.core_stall  = core_req & ~core_gnt;
  assign bus.host_gnt    = host_gnt;
  assign bus.host_rdata  = host_rdata_q;
  assign bus.host_rvalid = host_rvalid_q;
  assign bus.mem_wr_en   = mem_wr_en;
  assign bus.mem_rd_en   = mem_rd_en;
  assign bus.mem_addr    = mem_addr;
  assign bus.mem_wdata   = mem_wdata;
  assign bus.stall_cnt   = stall_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized and directed bench for dmem_arbiter against a rule-level reference model.
module tb_dmem_arbiter;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int LOCK_MAX = 4;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();
  dmem_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(LOCK_MAX)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));

  int n_vec = 0;
  int n_err = 0;

  // Reference model: who won last, length of the current locked host run, stall tally.
  int            m_last;   // 1 = core, 2 = host
  int            m_burst;
  int            m_stall;
  logic [DW-1:0] m_rdata;
  bit            m_rvalid;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_last = 2; m_burst = 0; m_stall = 0; m_rdata = '0; m_rvalid = 0;
  endtask

  // 0 = nobody, 1 = core, 2 = host
  function automatic int model_winner();
    bit cr, hr;
    cr = bus.core_rd | bus.core_wr;
    hr = bus.host_req;
    if (Reset || (!cr && !hr)) return 0;
    if (cr && !hr) return 1;
    if (hr && !cr) return 2;
    if (m_burst > 0 && bus.host_lock) return (m_burst >= LOCK_MAX) ? 1 : 2;
    return (m_last == 2) ? 1 : 2;
  endfunction

  task automatic drive(input bit cr, input bit cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                       input bit hr, input bit hw, input bit hl, input logic [AW-1:0] ha,
                       input logic [DW-1:0] hd, input logic [DW-1:0] mr);
    bus.core_rd = cr; bus.core_wr = cw; bus.core_addr = ca; bus.core_wdata = cd;
    bus.host_req = hr; bus.host_we = hw; bus.host_lock = hl; bus.host_addr = ha;
    bus.host_wdata = hd; bus.mem_rdata = mr;
  endtask

  // Called at posedge+1 (or later before the next edge); returns at posedge+1.
  task automatic step(input bit full, output int w);
    bit cr;
    #2;
    w  = model_winner();
    cr = bus.core_rd | bus.core_wr;
    if (full) begin
      check("host_gnt", 32'(bus.host_gnt), 32'(w == 2));
      check("core_stall", 32'(bus.core_stall), 32'(cr && w != 1));
      check("mem_wr_en", 32'(bus.mem_wr_en), 32'((w == 1 && bus.core_wr) || (w == 2 && bus.host_we)));
      check("mem_rd_en", 32'(bus.mem_rd_en), 32'((w == 1 && !bus.core_wr) || (w == 2 && !bus.host_we)));
      check("core_rdata", 32'(bus.core_rdata), 32'(bus.mem_rdata));
      if (w == 1) begin
        check("mem_addr_core", 32'(bus.mem_addr), 32'(bus.core_addr));
        if (bus.core_wr) check("mem_wdata_core", 32'(bus.mem_wdata), 32'(bus.core_wdata));
      end else if (w == 2) begin
        check("mem_addr_host", 32'(bus.mem_addr), 32'(bus.host_addr));
        if (bus.host_we) check("mem_wdata_host", 32'(bus.mem_wdata), 32'(bus.host_wdata));
      end
    end
    @(posedge Clk);
    if (w == 1) m_last = 1;
    if (w == 2) m_last = 2;
    m_burst  = (w == 2 && bus.host_lock) ? ((m_burst >= LOCK_MAX) ? LOCK_MAX : m_burst + 1) : 0;
    if (cr && w != 1 && m_stall < 16'hFFFF) m_stall++;
    m_rvalid = (w == 2 && !bus.host_we);
    if (m_rvalid) m_rdata = bus.mem_rdata;
    #1;
    if (full) begin
      check("host_rvalid", 32'(bus.host_rvalid), 32'(m_rvalid));
      check("host_rdata", 32'(bus.host_rdata), 32'(m_rdata));
      check("stall_cnt", 32'(bus.stall_cnt), 32'(m_stall));
    end
  endtask

  task automatic check_reset();
    check("rst_host_gnt", 32'(bus.host_gnt), 32'd0);
    check("rst_mem_wr_en", 32'(bus.mem_wr_en), 32'd0);
    check("rst_mem_rd_en", 32'(bus.mem_rd_en), 32'd0);
    check("rst_core_stall", 32'(bus.core_stall), 32'(bus.core_rd | bus.core_wr));
    check("rst_stall_cnt", 32'(bus.stall_cnt), 32'd0);
    check("rst_host_rvalid", 32'(bus.host_rvalid), 32'd0);
    check("rst_host_rdata", 32'(bus.host_rdata), 32'd0);
  endtask

  // Entered at posedge+1; asserts reset between edges and releases it after the next edge.
  task automatic reset_pulse();
    #1 Reset = 1'b1;
    #1 check_reset();
    model_reset();
    @(posedge Clk);
    #1 Reset = 1'b0;
  endtask

  initial begin
    int w;
    int guard;
    int stalls;
    Reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #1 check_reset();
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;

    // Both request right after reset: core wins the tie, then the host.
    drive(1, 0, 8'h11, 0, 1, 0, 0, 8'h22, 0, 8'h5A);
    #1 check("tie1_host_gnt", 32'(bus.host_gnt), 32'd0);
    check("tie1_core_stall", 32'(bus.core_stall), 32'd0);
    step(1, w);
    #1 check("tie2_host_gnt", 32'(bus.host_gnt), 32'd1);
    check("tie2_core_stall", 32'(bus.core_stall), 32'd1);
    step(1, w);
    check("tie2_stall_cnt", 32'(bus.stall_cnt), 32'd1);

    // Host read: data and valid appear one cycle later, valid for one cycle only.
    drive(0, 0, 0, 0, 1, 0, 0, 8'h20, 0, 8'h3C);
    #1 check("hrd_gnt", 32'(bus.host_gnt), 32'd1);
    check("hrd_addr", 32'(bus.mem_addr), 32'h20);
    step(1, w);
    check("hrd_rdata", 32'(bus.host_rdata), 32'h3C);
    check("hrd_rvalid", 32'(bus.host_rvalid), 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 8'hEE);
    step(1, w);
    check("hrd_rvalid_drop", 32'(bus.host_rvalid), 32'd0);

    // Lone core read passes memory data straight through.
    drive(1, 0, 8'h10, 0, 0, 0, 0, 0, 0, 8'hA5);
    #1 check("crd_rd_en", 32'(bus.mem_rd_en), 32'd1);
    check("crd_addr", 32'(bus.mem_addr), 32'h10);
    check("crd_rdata", 32'(bus.core_rdata), 32'hA5);
    check("crd_stall", 32'(bus.core_stall), 32'd0);
    step(1, w);

    // Read and write together: write wins.
    drive(1, 1, 8'h05, 8'h77, 0, 0, 0, 0, 0, 0);
    #1 check("cwr_wr_en", 32'(bus.mem_wr_en), 32'd1);
    check("cwr_rd_en", 32'(bus.mem_rd_en), 32'd0);
    check("cwr_wdata", 32'(bus.mem_wdata), 32'h77);
    check("cwr_addr", 32'(bus.mem_addr), 32'h05);
    step(1, w);

    // Locked burst against a waiting core write: four host grants, then the core.
    reset_pulse();
    drive(0, 1, 8'h30, 8'h01, 0, 0, 0, 0, 0, 0);
    step(1, w);
    drive(0, 1, 8'h30, 8'h02, 1, 1, 1, 8'h40, 8'h99, 0);
    for (int k = 1; k <= 5; k++) begin
      #1 check($sformatf("lock_c%0d_host_gnt", k), 32'(bus.host_gnt), 32'(k <= LOCK_MAX));
      step(1, w);
    end
    check("lock_stall_cnt", 32'(bus.stall_cnt), 32'd4);

    // A lock raised without a request does nothing.
    drive(1, 0, 8'h01, 0, 0, 0, 1, 0, 0, 0);
    #1 check("lock_noreq_gnt", 32'(bus.host_gnt), 32'd0);
    step(1, w);

    // Random traffic with the lock biased on, plus occasional resets.
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), AW'($urandom), DW'($urandom),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
            AW'($urandom), DW'($urandom), DW'($urandom));
      if ($urandom_range(0, 299) == 0) reset_pulse();
      else step(1, w);
    end

    // Stall counter saturation under continuous locked bursts.
    reset_pulse();
    drive(0, 1, 8'h55, 8'h66, 1, 1, 1, 8'h77, 8'h88, 0);
    guard = 0;
    while (m_stall < 16'hFFFE && guard < 90000) begin
      step(0, w);
      guard++;
    end
    check("sat_pre", 32'(bus.stall_cnt), 32'hFFFE);
    stalls = 0;
    guard  = 0;
    while (stalls < 3 && guard < 10) begin
      step(1, w);
      if (w != 1) stalls++;
      guard++;
    end
    check("sat_stalls_seen", 32'(stalls), 32'd3);
    check("sat_value", 32'(bus.stall_cnt), 32'hFFFF);

    // Reset in the middle of a locked host grant, then the core is favoured.
    guard = 0;
    while (model_winner() != 2 && guard < 10) begin
      step(1, w);
      guard++;
    end
    #1 check("mid_burst_gnt", 32'(bus.host_gnt), 32'd1);
    reset_pulse();
    #1 check("post_rst_host_gnt", 32'(bus.host_gnt), 32'd0);
    check("post_rst_core_stall", 32'(bus.core_stall), 32'd0);
    step(1, w);
    step(1, w);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
